// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
// PISO_PARITY_EN (optional) adds an even-parity bit after the data bits.
package piso_pkg;

   localparam int PISO_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } piso_state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; loads WIDTH-1 and stops at 0 (never wraps).
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(WIDTH - 1);
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out serializer with valid/ready input handshake.
// Build option PISO_PARITY_EN appends an even-parity bit as the last frame bit.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             sdo_last,
   output logic [1:0]       state_dbg
);

   // Handshake: a word transfers on a rising edge where din_valid and din_ready
   // are both 1. din_ready depends on state/counter only, so upstream may hold
   // din_valid with a stable din until that edge.

   piso_state_t      state;
   piso_state_t      state_nxt;
   logic [WIDTH-1:0] shreg;
   logic             cnt_zero;
   logic             accept;

   assign accept    = din_valid & din_ready;
   assign state_dbg = state;

   piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept),
      .dec     (state == SHIFT),
      .zero    (cnt_zero)
   );

`ifdef PISO_PARITY_EN
   logic par;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par <= 1'b0;
      end else if (accept) begin
         par <= 1'b0;
      end else if (state == SHIFT) begin
         par <= par ^ shreg[WIDTH-1];
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            shreg <= din;
         end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Serial outputs derive from registered state only; the final frame cycle
   // doubles as the load slot so held din_valid gives gap-free frames.
   always_comb begin
      state_nxt = state;
      din_ready = 1'b0;
      sdo       = 1'b0;
      sdo_valid = 1'b0;
      sdo_last  = 1'b0;
      case (state)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            sdo       = shreg[WIDTH-1];
            sdo_valid = 1'b1;
            if (cnt_zero) begin
`ifdef PISO_PARITY_EN
               state_nxt = PARITY;
`else
               sdo_last  = 1'b1;
               din_ready = 1'b1;
               state_nxt = din_valid ? SHIFT : IDLE;
`endif
            end
         end
         PARITY: begin
`ifdef PISO_PARITY_EN
            sdo       = par;
            sdo_valid = 1'b1;
            sdo_last  = 1'b1;
            din_ready = 1'b1;
            state_nxt = din_valid ? SHIFT : IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: vector table, hand-written corner
// sequences and randomized traffic against a bit-queue reference model.
module tb_piso_serializer;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FLEN = W + 1;
   localparam bit PAR  = 1'b1;
`else
   localparam int FLEN = W;
   localparam bit PAR  = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         din_ready;
   logic         sdo;
   logic         sdo_valid;
   logic         sdo_last;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one entry per expected serial cycle, {bit, last}.
   logic [1:0]   exp_q[$];
   logic [W-1:0] sipo = '0;

   piso_serializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .sdo       (sdo),
      .sdo_valid (sdo_valid),
      .sdo_last  (sdo_last),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // Downstream 4-bit SIPO shift register fed by sdo.
   always @(posedge clk) sipo <= {sipo[W-2:0], sdo};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_sdo"}, sdo, 0);
      check({tag, "_sdo_valid"}, sdo_valid, 0);
      check({tag, "_sdo_last"}, sdo_last, 0);
   endtask

   // Frame for a word, straight from the framing rules: MSB first, optional parity.
   task automatic push_frame(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) exp_q.push_back({w[i], (!PAR && i == 0)});
      if (PAR) exp_q.push_back({^w, 1'b1});
   endtask

   // Send one isolated word and compare against an explicit MSB-first bit list.
   task automatic send_frame(input string tag, input logic [W-1:0] w, input logic [FLEN-1:0] bits);
      din = w;
      din_valid = 1'b1;
      #1 check({tag, "_ready_accept"}, din_ready, 1);
      step();
      din_valid = 1'b0;
      for (int i = 0; i < FLEN; i++) begin
         check($sformatf("%s_bit%0d", tag, i), sdo, bits[FLEN-1-i]);
         check($sformatf("%s_valid%0d", tag, i), sdo_valid, 1);
         check($sformatf("%s_last%0d", tag, i), sdo_last, (i == FLEN - 1));
         step();
      end
      check_idle_outputs({tag, "_after"});
   endtask

`ifndef PISO_PARITY_EN
   typedef struct {
      logic [W-1:0] din;
      logic         vld;
      logic         rdy;
      logic         sdo;
      logic         sv;
      logic         sl;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [W-1:0] d, input logic v, input logic r,
                               input logic s, input logic sv, input logic sl);
      vec_t e;
      e.din = d; e.vld = v; e.rdy = r; e.sdo = s; e.sv = sv; e.sl = sl;
      vecs.push_back(e);
   endfunction
`endif

   initial begin
      logic acc;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_ready", din_ready, 1);
      check("reset_state", state_dbg, 0);
      reset_n = 1'b1;
      step();

`ifndef PISO_PARITY_EN
      // Row: inputs this cycle, din_ready this cycle, outputs after the edge.
      // 4'b1011 single word
      add(4'hB, 1, 1, 1, 1, 0);
      add(4'h0, 0, 0, 0, 1, 0);
      add(4'h0, 0, 0, 1, 1, 0);
      add(4'h0, 0, 0, 1, 1, 1);
      add(4'h0, 0, 1, 0, 0, 0);
      // 4'hA then 4'h5 with din_valid held
      add(4'hA, 1, 1, 1, 1, 0);
      add(4'h5, 1, 0, 0, 1, 0);
      add(4'h5, 1, 0, 1, 1, 0);
      add(4'h5, 1, 0, 0, 1, 1);
      add(4'h5, 1, 1, 0, 1, 0);
      add(4'h0, 0, 0, 1, 1, 0);
      add(4'h0, 0, 0, 0, 1, 0);
      add(4'h0, 0, 0, 1, 1, 1);
      add(4'h0, 0, 1, 0, 0, 0);
      // 4'hF offered while a 4'h0 frame is busy
      add(4'h0, 1, 1, 0, 1, 0);
      add(4'hF, 1, 0, 0, 1, 0);
      add(4'hF, 1, 0, 0, 1, 0);
      add(4'hF, 1, 0, 0, 1, 1);
      add(4'hF, 1, 1, 1, 1, 0);
      add(4'h0, 0, 0, 1, 1, 0);
      add(4'h0, 0, 0, 1, 1, 0);
      add(4'h0, 0, 0, 1, 1, 1);
      add(4'h0, 0, 1, 0, 0, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         din = vecs[i].din;
         din_valid = vecs[i].vld;
         #1 check($sformatf("vec%0d_ready", i), din_ready, vecs[i].rdy);
         step();
         check($sformatf("vec%0d_sdo", i), sdo, vecs[i].sdo);
         check($sformatf("vec%0d_sdo_valid", i), sdo_valid, vecs[i].sv);
         check($sformatf("vec%0d_sdo_last", i), sdo_last, vecs[i].sl);
         if (i == 4) check("sipo_q", sipo, 4'b1011);
      end
      din_valid = 1'b0;
`else
      send_frame("par1011", 4'b1011, 5'b10111);
      send_frame("par1001", 4'b1001, 5'b10010);
`endif

      // Reset pulsed mid-frame after bit 2 of 4'hC
      din = 4'hC;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      check("rst_bit1", sdo, 1);
      step();
      check("rst_bit2", sdo, 1);
      check("rst_bit2_valid", sdo_valid, 1);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("rst_async");
      check("rst_async_ready", din_ready, 1);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst_quiet%0d", i), sdo_valid, 0);
      end
`ifdef PISO_PARITY_EN
      send_frame("fresh9", 4'h9, 5'b10010);
`else
      send_frame("fresh9", 4'h9, 4'b1001);
`endif

      // Randomized traffic against the bit-queue model, with occasional resets
      exp_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         din = W'($urandom);
         din_valid = ($urandom_range(0, 3) != 0);
         #1 check("rnd_ready", din_ready, (exp_q.size() <= 1));
         acc = din_valid && (exp_q.size() <= 1);
         @(posedge clk);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (acc) push_frame(din);
         #1;
         if (exp_q.size() > 0) begin
            check("rnd_sdo", sdo, exp_q[0][1]);
            check("rnd_sdo_valid", sdo_valid, 1);
            check("rnd_sdo_last", sdo_last, exp_q[0][0]);
         end else begin
            check_idle_outputs("rnd_idle");
         end
         if ($urandom_range(0, 59) == 0) begin
            reset_n = 1'b0;
            #1;
            exp_q.delete();
            check_idle_outputs("rnd_reset");
            check("rnd_reset_ready", din_ready, 1);
            reset_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer sitting directly upstream of the 4-bit serial-in/parallel-out shift register. It accepts a parallel word over a valid/ready handshake and emits it MSB-first on a one-bit serial line, one bit per clock. This bit order makes the downstream deserializer's parallel output equal the original word after WIDTH shifts. A per-bit valid strobe and a last-bit marker frame the stream.

## Interface
- WIDTH, 4, data word width in bits (≥2).
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  serializer can accept a word this cycle.
- sdo  output  1  serial data out; feeds the D input of the downstream shift register.
- sdo_valid  output  1  sdo carries a frame bit this cycle.
- sdo_last  output  1  sdo is the final bit of the current frame.

## Operation
- States: IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
- A word is accepted on a rising edge where din_valid=1 and din_ready=1. On acceptance:
  - din is captured into a WIDTH-bit shift register.
  - A bit counter loads WIDTH-1.
  - The state becomes SHIFT.
- In SHIFT:
  - sdo = shreg[WIDTH-1] and sdo_valid=1.
  - Each edge shifts shreg left by one, inserting 0, and decrements the counter.
  - sdo_last=1 when the counter is 0 and PARITY is not compiled in.
- Leaving SHIFT at counter 0:
  - Parity compiled in: go to PARITY.
  - Otherwise, if a word is accepted on the same edge: reload and stay in SHIFT, so there is no gap cycle.
  - Otherwise: go to IDLE.
- din_ready is combinational from state and counter only, never from din_valid:
  - 1 in IDLE.
  - 1 in the final-bit cycle (SHIFT with counter 0 and no parity, or PARITY).
  - 0 otherwise.
- din_valid asserted while din_ready=0 is ignored. The word is not captured and the upstream source must hold it.
- Outputs in IDLE: sdo=0, sdo_valid=0, sdo_last=0.
- Reset (async assert, any state, including mid-frame):
  - State becomes IDLE; shreg, counter and parity accumulator clear to 0.
  - sdo=0, sdo_valid=0, sdo_last=0 immediately.
  - din_ready=1.
  - The partial frame is dropped; no resume.
- Counter width is $clog2(WIDTH). It never wraps: decrement happens only when nonzero, and reload happens at 0.

## Timing
- Latency: first bit (din[WIDTH-1]) appears on sdo in the cycle after the accepting edge.
- Bit k (MSB = 0) appears k cycles later.
- Frame length is WIDTH cycles, or WIDTH+1 cycles with parity.
- Back-to-back frames are contiguous: sdo_valid stays high across the frame boundary when din_valid is held.
- Throughput is one word per WIDTH (or WIDTH+1) cycles.
- sdo, sdo_valid and sdo_last are driven from registered state only (no combinational path from din or din_valid).

## Configuration
- PISO_PARITY_EN defined:
  - An even-parity bit (XOR of all WIDTH data bits, accumulated while shifting) is sent in a PARITY state after the last data bit.
  - In that cycle sdo_valid=1 and sdo_last=1.
  - Back-to-back loading occurs in PARITY instead of the last data cycle.
- PISO_PARITY_EN undefined: no PARITY state and no parity register; the frame is exactly WIDTH bits.

## Structure
- Shared package piso_pkg holds:
  - The state typedef (enum IDLE, SHIFT, PARITY).
  - The default-width constant PISO_WIDTH_DEF = 4.
- One sub-module, piso_bit_counter, is natural: a loadable down-counter with a zero flag, parameterized by WIDTH.
- Shift register, FSM and parity logic stay in the top module.

## Test plan
- Reset, then din=4'b1011 with din_valid for one cycle:
  - sdo = 1,0,1,1 on the next 4 cycles with sdo_valid=1, sdo_last only on the 4th.
  - A downstream SIPO shows Q=4'b1011 after the 4th bit edge.
- din_valid held with 4'hA then 4'h5: 8 contiguous sdo_valid cycles carrying 1,0,1,0,0,1,0,1; din_ready high only in cycles 4 and 8.
- din_valid asserted with 4'hF during bits 1–3 of a 4'h0 frame: not accepted, sdo stays 0,0,0,0; 4'hF is accepted at the last-bit cycle.
- reset_n pulsed low after bit 2 of 4'hC: sdo, sdo_valid and sdo_last go 0 at once; din_ready=1; no further bits; the next word starts a fresh frame.
- PISO_PARITY_EN with 4'b1011: 5-bit frame 1,0,1,1,1 with sdo_last on the 5th. With 4'b1001 the parity bit is 0.
